// File: rtl/ysyx_210544_if_stage_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ysyx_210544_if_stage_pkg;

    localparam int BUS_64 = 64;
    localparam int BUS_32 = 32;

    // Synthetic instruction presented when a fetch is abandoned (addi x0,x0,0).
    localparam logic [BUS_32-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_S_IDLE = 2'd0,
        IF_S_REQ  = 2'd1,
        IF_S_DONE = 2'd2,
        IF_S_WAIT = 2'd3
    } if_state_e;

    // Bus reads are doubleword aligned; the low three address bits are dropped.
    function automatic logic [BUS_64-1:0] if_dword_addr(input logic [BUS_64-1:0] addr);
        return addr & ~64'h7;
    endfunction

    // Instruction addresses are word aligned; redirect targets lose their low two bits.
    function automatic logic [BUS_64-1:0] if_word_align(input logic [BUS_64-1:0] addr);
        return addr & ~64'h3;
    endfunction

    // Pick the 32-bit instruction out of the returned doubleword.
    function automatic logic [BUS_32-1:0] if_sel_word(input logic             sel_hi,
                                                       input logic [BUS_64-1:0] rdata);
        return sel_hi ? rdata[63:32] : rdata[31:0];
    endfunction

endpackage

// File: rtl/ysyx_210544_if_stage.sv
// Instruction fetch: one read per instruction, presents pc/inst/nocmt with a 1-cycle strobe.
// Latency: fetched strobe the cycle after bus_ready; next request the cycle after writeback.
// Backpressure: bus_req held until bus_ready; no new fetch until writeback. Macro YSYX_210544_IF_TIMEOUT_EN bounds the bus wait.
module ysyx_210544_if_stage
    import ysyx_210544_if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC       = 64'h0000_0000_8000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_writebacked_req,
    input  logic        i_if_pc_jmp,
    input  logic [63:0] i_if_pc_jmpaddr,
    output logic        o_if_bus_req,
    output logic [63:0] o_if_bus_addr,
    input  logic        i_if_bus_ready,
    input  logic [63:0] i_if_bus_rdata,
    output logic        o_if_fetched_req,
    output logic [63:0] o_if_pc,
    output logic [31:0] o_if_inst,
    output logic        o_if_nocmt
);

    // The timeout compare needs at least one wait cycle to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    if_state_e   state_q, state_d;
    logic        boot_q,  boot_d;
    logic [63:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic        nocmt_q, nocmt_d;

`ifdef YSYX_210544_IF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state and datapath updates; every field holds unless its state acts on it.
    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        nocmt_d   = nocmt_q;
`ifdef YSYX_210544_IF_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        unique case (state_q)
            IF_S_IDLE: begin
                if (boot_q) begin
                    boot_d  = 1'b0;
                    state_d = IF_S_REQ;
`ifdef YSYX_210544_IF_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            IF_S_REQ: begin
                // A real response wins even on the last allowed wait cycle.
                if (i_if_bus_ready) begin
                    inst_d  = if_sel_word(pc_q[2], i_if_bus_rdata);
                    nocmt_d = 1'b0;
                    state_d = IF_S_DONE;
                end
`ifdef YSYX_210544_IF_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up on the bus and hand decode a NOP that difftest skips.
                    inst_d  = INST_NOP;
                    nocmt_d = 1'b1;
                    state_d = IF_S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            IF_S_DONE: begin
                state_d = IF_S_WAIT;
            end
            IF_S_WAIT: begin
                // Redirect is only honoured together with the retire pulse.
                if (i_if_writebacked_req) begin
                    pc_d    = i_if_pc_jmp ? if_word_align(i_if_pc_jmpaddr) : pc_q + 64'd4;
                    state_d = IF_S_REQ;
`ifdef YSYX_210544_IF_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IF_S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IF_S_IDLE;
            boot_q    <= 1'b1;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            nocmt_q   <= 1'b0;
`ifdef YSYX_210544_IF_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            nocmt_q   <= nocmt_d;
`ifdef YSYX_210544_IF_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state register so they never glitch.
    always_comb begin
        o_if_bus_req     = (state_q == IF_S_REQ);
        o_if_fetched_req = (state_q == IF_S_DONE);
        o_if_bus_addr    = if_dword_addr(pc_q);
        o_if_pc          = pc_q;
        o_if_inst        = inst_q;
        o_if_nocmt       = nocmt_q;
    end

endmodule

// File: tb/tb_ysyx_210544_if_stage.sv
module tb_ysyx_210544_if_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam int          TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req;
    logic        jmp;
    logic [63:0] jmpaddr;
    logic        bus_req;
    logic [63:0] bus_addr;
    logic        bus_ready;
    logic [63:0] bus_rdata;
    logic        fetched;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_nocmt;

    ysyx_210544_if_stage #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_if_writebacked_req (wb_req),
        .i_if_pc_jmp          (jmp),
        .i_if_pc_jmpaddr      (jmpaddr),
        .o_if_bus_req         (bus_req),
        .o_if_bus_addr        (bus_addr),
        .i_if_bus_ready       (bus_ready),
        .i_if_bus_rdata       (bus_rdata),
        .o_if_fetched_req     (fetched),
        .o_if_pc              (if_pc),
        .o_if_inst            (if_inst),
        .o_if_nocmt           (if_nocmt)
    );

    always #5 clk = ~clk;

    // Reference state: the architectural PC the next fetch must use.
    logic [63:0] model_pc;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Wait (bounded) at negedges until a read request is visible.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_req === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("bus_req_rise", {63'd0, bus_req}, 64'd1);
    endtask

    // One fetch: respond after lat request cycles, optionally poke a stray writeback mid-request.
    task automatic fetch(input int lat, input bit spur_wb, input logic [63:0] rdata);
        bit          ok;
        logic [31:0] exp_inst;
        wait_req(ok);
        if (!ok) return;
        chk("bus_addr", bus_addr, model_pc & ~64'h7);
        for (int i = 0; i < lat; i++) begin
            if (spur_wb && i == 0) begin
                wb_req  = 1'b1;
                jmp     = 1'b1;
                jmpaddr = {$urandom, $urandom};
            end
            @(negedge clk);
            wb_req = 1'b0;
            jmp    = 1'b0;
            chk("bus_req_hold", {63'd0, bus_req}, 64'd1);
            chk("no_early_fetch", {63'd0, fetched}, 64'd0);
        end
        bus_ready = 1'b1;
        bus_rdata = rdata;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = {$urandom, $urandom};
        exp_inst  = model_pc[2] ? rdata[63:32] : rdata[31:0];
        chk("fetched_hi", {63'd0, fetched}, 64'd1);
        chk("pc", if_pc, model_pc);
        chk("inst", {32'd0, if_inst}, {32'd0, exp_inst});
        chk("nocmt", {63'd0, if_nocmt}, 64'd0);
        chk("bus_req_drop", {63'd0, bus_req}, 64'd0);
        @(negedge clk);
        chk("fetched_pulse", {63'd0, fetched}, 64'd0);
    endtask

    // Retire the presented instruction, with or without a redirect.
    task automatic writeback(input bit j, input logic [63:0] tgt);
        wb_req  = 1'b1;
        jmp     = j;
        jmpaddr = tgt;
        @(negedge clk);
        wb_req  = 1'b0;
        jmp     = 1'b0;
        model_pc = j ? (tgt & ~64'h3) : model_pc + 64'd4;
    endtask

    // Stray bus responses while nothing is outstanding must change nothing.
    task automatic spur_ready(input int n);
        logic [31:0] held;
        held = if_inst;
        for (int i = 0; i < n; i++) begin
            bus_ready = 1'b1;
            bus_rdata = {$urandom, $urandom};
            @(negedge clk);
            bus_ready = 1'b0;
            chk("spur_no_fetch", {63'd0, fetched}, 64'd0);
            chk("spur_no_req", {63'd0, bus_req}, 64'd0);
            chk("spur_inst_held", {32'd0, if_inst}, {32'd0, held});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;
        int cnt;
        rst       = 1'b1;
        wb_req    = 1'b0;
        jmp       = 1'b0;
        jmpaddr   = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        model_pc  = RST_PC;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
        chk("rst_fetched", {63'd0, fetched}, 64'd0);
        chk("rst_pc", if_pc, RST_PC);
        chk("rst_inst", {32'd0, if_inst}, 64'd0);
        chk("rst_nocmt", {63'd0, if_nocmt}, 64'd0);
        rst = 1'b0;

        // Boot fetch, low word, 3 wait cycles.
        fetch(3, 1'b0, 64'hAAAA_BBBB_1111_2222);
        // Sequential: same doubleword, high word.
        writeback(1'b0, 64'd0);
        fetch(2, 1'b0, 64'hCAFE_F00D_DEAD_BEEF);
        // Redirect with misaligned target; zero-wait response.
        writeback(1'b1, 64'h0000_0000_8000_0103);
        fetch(0, 1'b0, 64'h0123_4567_89AB_CDEF);
        // Stray ready in WAIT, stray writeback in REQ.
        spur_ready(2);
        writeback(1'b0, 64'd0);
        fetch(3, 1'b1, 64'h1357_9BDF_2468_ACE0);

        // Asynchronous reset in the middle of a request.
        writeback(1'b0, 64'd0);
        wait_req(ok);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bus_req", {63'd0, bus_req}, 64'd0);
        chk("mid_rst_pc", if_pc, RST_PC);
        chk("mid_rst_fetched", {63'd0, fetched}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC;
        fetch(1, 1'b0, 64'h5555_6666_7777_8888);

        // PC wrap at the top of the address space.
        writeback(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(1, 1'b0, 64'h9999_AAAA_BBBB_CCCC);
        writeback(1'b0, 64'd0);
        chk("wrap_model", model_pc, 64'd0);
        fetch(2, 1'b0, 64'hDDDD_EEEE_FFFF_0000);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            writeback(1'($urandom_range(0, 1)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                lat = 0;
            end else begin
                lat = $urandom_range(1, 4);
            end
            fetch(lat, (lat > 0) && ($urandom_range(0, 2) == 0), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) spur_ready($urandom_range(1, 2));
        end

`ifdef YSYX_210544_IF_TIMEOUT_EN
        // Bus never answers: synthetic NOP after TMO request cycles.
        writeback(1'b0, 64'd0);
        wait_req(ok);
        cnt = 0;
        while (bus_req === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", 64'(cnt), 64'(TMO));
        chk("tmo_fetched", {63'd0, fetched}, 64'd1);
        chk("tmo_inst", {32'd0, if_inst}, 64'h13);
        chk("tmo_nocmt", {63'd0, if_nocmt}, 64'd1);
        chk("tmo_pc", if_pc, model_pc);
        @(negedge clk);
        spur_ready(1);
        writeback(1'b0, 64'd0);
        fetch(1, 1'b0, {$urandom, $urandom});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
